// File: rtl/prio_enc_pkg.sv
// Shared widths and types for the 16-input priority encoder.
package prio_enc_pkg;
   localparam int N_IN  = 16;
   localparam int IDX_W = 4;
   typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/prio_enc4.sv
// 4-input priority encoder: a[3] highest priority, y = 0 when nothing is set.
module prio_enc4 (
   input  logic [3:0] a,
   output logic [1:0] y,
   output logic       z
);
   always_comb begin
      y = 2'd0;
      z = |a;
      if (a[3])      y = 2'd3;
      else if (a[2]) y = 2'd2;
      else if (a[1]) y = 2'd1;
   end
endmodule

// File: rtl/priority_encoder_top.sv
// 16-input priority encoder built as two levels of 4-input encoders,
// with zero-latency outputs and a registered copy for clocked consumers.
module priority_encoder_top
   import prio_enc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [N_IN-1:0] W,
   output idx_t            Y,
   output logic            Z,
   output idx_t            Y_q,
   output logic            Z_q
);
   logic [1:0] grp_y [4];
   logic [3:0] grp_z;
   logic [1:0] grp_sel;
   idx_t       y_d;
   logic       z_d;

   for (genvar g = 0; g < 4; g++) begin : g_nibble
      prio_enc4 u_grp (
         .a (W[4*g +: 4]),
         .y (grp_y[g]),
         .z (grp_z[g])
      );
   end

   // Second level picks the highest non-empty nibble; its z is the global valid.
   prio_enc4 u_sel (
      .a (grp_z),
      .y (grp_sel),
      .z (Z)
   );

   assign Y = {grp_sel, grp_y[grp_sel]};

   always_comb begin
      y_d = Y;
      z_d = Z;
      if (reset) begin
         y_d = '0;
         z_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      Y_q <= y_d;
      Z_q <= z_d;
   end
endmodule

// File: tb/tb_priority_encoder_top.sv
// Randomized and directed bench for priority_encoder_top against a highest-set-bit model.
module tb_priority_encoder_top;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] W = 16'h0000;
   logic [3:0]  Y, Y_q;
   logic        Z, Z_q;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic [3:0] exp_yq = 4'd0;
   logic       exp_zq = 1'b0;
   bit         q_known = 1'b0;
   bit         run = 1'b1;

   always #5 clk = ~clk;

   priority_encoder_top dut (
      .clk   (clk),
      .reset (reset),
      .W     (W),
      .Y     (Y),
      .Z     (Z),
      .Y_q   (Y_q),
      .Z_q   (Z_q)
   );

   function automatic logic [3:0] ref_y(input logic [15:0] w);
      ref_y = 4'd0;
      for (int i = 0; i < 16; i++)
         if (w[i]) ref_y = i[3:0];
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (W=%h reset=%0b t=%0t)",
                  name, act, exp, W, reset, $time);
      end
   endtask

   // Model of the output register: what Y_q/Z_q must hold after each edge.
   always @(posedge clk) begin
      exp_yq  <= reset ? 4'd0 : ref_y(W);
      exp_zq  <= reset ? 1'b0 : (W != 16'h0000);
      q_known <= 1'b1;
   end

   always @(negedge clk) begin
      if (run) begin
         chk("Y", {12'd0, Y}, {12'd0, ref_y(W)});
         chk("Z", {15'd0, Z}, {15'd0, W != 16'h0000});
         if (q_known) begin
            chk("Y_q", {12'd0, Y_q}, {12'd0, exp_yq});
            chk("Z_q", {15'd0, Z_q}, {15'd0, exp_zq});
         end
      end
   end

   task automatic apply(input logic [15:0] w, input logic rst);
      @(posedge clk);
      #2;
      W = w;
      reset = rst;
   endtask

   task automatic lit(input string name, input logic [3:0] ey, input logic ez);
      #1;
      chk({name, "_y"}, {12'd0, Y}, {12'd0, ey});
      chk({name, "_z"}, {15'd0, Z}, {15'd0, ez});
   endtask

   initial begin
      logic [15:0] w;
      apply(16'h0000, 1'b1);
      apply(16'h0000, 1'b0);
      lit("zero", 4'd0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         w = 16'h0001 << i;
         apply(w, 1'b0);
         lit("walk1", i[3:0], 1'b1);
      end
      for (int i = 0; i < 16; i++) begin
         w = (16'h0001 << i) | ((16'h0001 << i) - 16'h0001);
         apply(w, 1'b0);
         lit("walk_noise", i[3:0], 1'b1);
      end

      apply(16'hFFFF, 1'b0); lit("ffff", 4'd15, 1'b1);
      apply(16'h8001, 1'b0); lit("8001", 4'd15, 1'b1);
      apply(16'h00FF, 1'b0); lit("00ff", 4'd7,  1'b1);
      apply(16'h0003, 1'b0); lit("0003", 4'd1,  1'b1);
      apply(16'h0101, 1'b0); lit("0101", 4'd8,  1'b1);
      apply(16'h1010, 1'b0); lit("1010", 4'd12, 1'b1);

      apply(16'h0400, 1'b0);
      @(posedge clk); #1;
      chk("reg_0400_yq", {12'd0, Y_q}, 16'd10);
      chk("reg_0400_zq", {15'd0, Z_q}, 16'd1);
      apply(16'h0000, 1'b0);
      @(posedge clk); #1;
      chk("reg_0000_yq", {12'd0, Y_q}, 16'd0);
      chk("reg_0000_zq", {15'd0, Z_q}, 16'd0);

      apply(16'h8000, 1'b1);
      @(posedge clk); #1;
      chk("rst_yq", {12'd0, Y_q}, 16'd0);
      chk("rst_zq", {15'd0, Z_q}, 16'd0);
      chk("rst_y",  {12'd0, Y},   16'd15);
      chk("rst_z",  {15'd0, Z},   16'd1);
      apply(16'h8000, 1'b0);
      @(posedge clk); #1;
      chk("rel_yq", {12'd0, Y_q}, 16'd15);
      chk("rel_zq", {15'd0, Z_q}, 16'd1);

      // Shifting the random word right gives sparse vectors so low codes appear too.
      for (int n = 0; n < 1000; n++) begin
         w = 16'($urandom);
         w = w >> $urandom_range(0, 16);
         apply(w, ($urandom_range(0, 24) == 0));
      end
      apply(16'h0000, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      run = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
